hazard_tnew_pipe: RTL
=====================

# hazard_tnew_pipe

Carries each instruction's destination register (GRF A3), remaining-latency count (Tnew) and PC from the D stage through the E, M and W pipeline registers of the five-stage CPU. It produces the E/M/W A3 and Tnew values that the stall unit compares against D-stage Tuse. On a stall it inserts a bubble into E. It also keeps a saturating count of bubble cycles for performance checks.

## Interface
- Parameters: none. Widths are fixed: A3 5 bits, Tnew 2 bits, PC 32 bits, counter 32 bits.
- Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `stall`  in  1  from the stall unit. When 1, the next E contents are a bubble; D is held by its own register.
- `D_RegWrite`  in  1  the D-stage instruction writes the GRF.
- `D_GRF_A3`  in  5  destination register of the D-stage instruction.
- `D_Tnew`  in  2  Tnew the instruction has on entering E: 0 = no result pending, 1 = ALU result, 2 = load.
- `D_PC`  in  32  PC of the D-stage instruction.
- `E_GRF_A3`, `M_GRF_A3`, `W_GRF_A3`  out  5 each  destination register per stage.
- `E_Tnew`, `M_Tnew`, `W_Tnew`  out  2 each  remaining latency per stage.
- `E_PC`, `M_PC`, `W_PC`  out  32 each  PC per stage.
- `W_GRF_WE`  out  1  combinational: 1 when `W_GRF_A3 != 0`.
- `bubble_cnt`  out  32  number of bubbles inserted since reset; saturates at 0xFFFFFFFF.

## Operation
- D capture (normalisation):
  - If `D_RegWrite == 0` or `D_GRF_A3 == 0`, the captured A3 is 0 and the captured Tnew is 0.
  - Otherwise A3 = `D_GRF_A3` and Tnew = `D_Tnew`.
  - `D_Tnew == 3` is illegal input and is captured as 2.
- E register:
  - If `stall == 1`: A3 = 0, Tnew = 0, PC = 0. This is the bubble.
  - Otherwise: the normalised D values.
- M register: A3 and PC copied from E. Tnew = E_Tnew − 1, saturating at 0.
- W register: A3 and PC copied from M. Tnew = M_Tnew − 1, saturating at 0.
- The E, M and W stages always advance; `stall` only affects what enters E.
- `bubble_cnt` increments by 1 on each clock edge where `stall == 1` and `reset == 0`. It holds at 0xFFFFFFFF once reached.
- Invariants checked by the bench:
  - Any stage with A3 = 0 has Tnew = 0.
  - W_Tnew is always 0 for any legal input.
  - Tnew never increases from one stage to the next.

## Timing
- Reset values: every output register is 0, i.e. all A3, Tnew, PC and `bubble_cnt`. `W_GRF_WE` is therefore 0.
- A `reset` asserted mid-stream clears all stages and the counter on that same edge. Reset has priority over `stall`: reset together with stall gives 0s and the counter stays 0.
- Latency:
  - D values appear on the E outputs 1 cycle after the edge that captures them.
  - They reach M at +2 and W at +3.
- `stall` is sampled at the same edge as the D inputs.
  - A stall held for N cycles inserts N consecutive bubbles in E.
  - The D instruction presented on the first edge with `stall == 0` is the one captured.
- The outputs are direct register outputs with no combinational path from the inputs, except `W_GRF_WE`, which derives from `W_GRF_A3` only. The stall unit may therefore use them in the same cycle without creating a loop.

## Test plan
- Reset check:
  - Stimulus: drive random inputs, then assert `reset` for 1 cycle.
  - Required response: all outputs 0 on the next cycle, `bubble_cnt` = 0.
- Load propagation:
  - Stimulus: D_RegWrite=1, A3=5, Tnew=2, PC=0x3000, then idle inputs (RegWrite=0).
  - Required response: E = (5, 2, 0x3000), then M = (5, 1), then W = (5, 0) with `W_GRF_WE` = 1.
- Stall bubble:
  - Stimulus: stall=1 for 2 cycles while D holds A3=8, Tnew=1, PC=0x3004; then stall=0.
  - Required response: E shows 2 bubbles (0, 0, 0), then (8, 1, 0x3004). `bubble_cnt` = 2.
- Normalisation:
  - Stimulus: A3=0, RegWrite=1, Tnew=2; then A3=9, RegWrite=0, Tnew=1.
  - Required response: both produce E_A3 = 0 and E_Tnew = 0. `W_GRF_WE` stays 0 as they drain.
- Back-to-back with saturation:
  - Stimulus: ALU (A3=3, Tnew=1), then load (A3=4, Tnew=2), then Tnew=3 (A3=6).
  - Required response: M_Tnew sequence 0, 1, 1 and W_Tnew always 0. The Tnew=3 instruction enters E as 2.
- Counter saturation and reset priority:
  - Stimulus: force `bubble_cnt` to 0xFFFFFFFE, hold stall=1 for 3 cycles, then assert reset and stall together.
  - Required response: counter reads FFFFFFFF, FFFFFFFF, FFFFFFFF, then 0 after the reset edge.

Source files
------------

// File: rtl/hazard_tnew_pipe.sv
// hazard_tnew_pipe
//
// Moves each instruction's GRF destination (A3), remaining result latency
// (Tnew) and PC from the D stage through the E, M and W pipeline registers.
// The stall unit compares these stage values against the D-stage Tuse.
// When a stall is requested, a bubble enters E. A saturating counter
// records how many bubbles have been inserted.
//
// Ports
//   clk                  system clock, rising edge
//   reset                synchronous, active-high
//   stall                insert a bubble into E on this edge
//   D_RegWrite           D-stage instruction writes the GRF
//   D_GRF_A3[4:0]        D-stage destination register
//   D_Tnew[1:0]          Tnew on entry to E (3 is illegal and is treated as 2)
//   D_PC[31:0]           D-stage PC
//   {E,M,W}_GRF_A3[4:0]  per-stage destination register
//   {E,M,W}_Tnew[1:0]    per-stage remaining latency
//   {E,M,W}_PC[31:0]     per-stage PC
//   W_GRF_WE             W_GRF_A3 != 0 (no path from any input)
//   bubble_cnt[31:0]     bubbles inserted since reset, saturating
module hazard_tnew_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        D_RegWrite,
    input  logic [4:0]  D_GRF_A3,
    input  logic [1:0]  D_Tnew,
    input  logic [31:0] D_PC,
    output logic [4:0]  E_GRF_A3,
    output logic [4:0]  M_GRF_A3,
    output logic [4:0]  W_GRF_A3,
    output logic [1:0]  E_Tnew,
    output logic [1:0]  M_Tnew,
    output logic [1:0]  W_Tnew,
    output logic [31:0] E_PC,
    output logic [31:0] M_PC,
    output logic [31:0] W_PC,
    output logic        W_GRF_WE,
    output logic [31:0] bubble_cnt
);

    logic [4:0]  e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
    logic [1:0]  e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
    logic [31:0] e_pc_q, e_pc_d, m_pc_q, m_pc_d, w_pc_q, w_pc_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    logic [4:0]  d_a3_norm;
    logic [1:0]  d_tnew_norm;

    // An instruction that does not write a real register carries no hazard.
    // Because of this, A3 = 0 always travels with Tnew = 0.
    always_comb begin
        d_a3_norm   = 5'd0;
        d_tnew_norm = 2'd0;
        if (D_RegWrite && (D_GRF_A3 != 5'd0)) begin
            d_a3_norm   = D_GRF_A3;
            d_tnew_norm = (D_Tnew == 2'd3) ? 2'd2 : D_Tnew;
        end
    end

    always_comb begin
        e_a3_d   = d_a3_norm;
        e_tnew_d = d_tnew_norm;
        e_pc_d   = D_PC;
        if (stall) begin
            e_a3_d   = 5'd0;
            e_tnew_d = 2'd0;
            e_pc_d   = 32'd0;
        end

        // Downstream stages always advance. Tnew counts down and stops at 0.
        m_a3_d   = e_a3_q;
        m_pc_d   = e_pc_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;

        w_a3_d   = m_a3_q;
        w_pc_d   = m_pc_q;
        w_tnew_d = (m_tnew_q == 2'd0) ? 2'd0 : m_tnew_q - 2'd1;

        bubble_cnt_d = bubble_cnt_q;
        if (stall && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3_q       <= 5'd0;
            e_tnew_q     <= 2'd0;
            e_pc_q       <= 32'd0;
            m_a3_q       <= 5'd0;
            m_tnew_q     <= 2'd0;
            m_pc_q       <= 32'd0;
            w_a3_q       <= 5'd0;
            w_tnew_q     <= 2'd0;
            w_pc_q       <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            e_a3_q       <= e_a3_d;
            e_tnew_q     <= e_tnew_d;
            e_pc_q       <= e_pc_d;
            m_a3_q       <= m_a3_d;
            m_tnew_q     <= m_tnew_d;
            m_pc_q       <= m_pc_d;
            w_a3_q       <= w_a3_d;
            w_tnew_q     <= w_tnew_d;
            w_pc_q       <= w_pc_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign E_GRF_A3   = e_a3_q;
    assign M_GRF_A3   = m_a3_q;
    assign W_GRF_A3   = w_a3_q;
    assign E_Tnew     = e_tnew_q;
    assign M_Tnew     = m_tnew_q;
    assign W_Tnew     = w_tnew_q;
    assign E_PC       = e_pc_q;
    assign M_PC       = m_pc_q;
    assign W_PC       = w_pc_q;
    assign W_GRF_WE   = (w_a3_q != 5'd0);
    assign bubble_cnt = bubble_cnt_q;

endmodule
